// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: decode in front of STAGES elastic slots.
// Define IMM_GEN_PIPE_STATS_EN to add the saturating illegal_cnt output.
module imm_gen_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 1,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
`ifdef IMM_GEN_PIPE_STATS_EN
    ,
    output logic [15:0]      illegal_cnt
`endif
);

    if ((XLEN != 32 && XLEN != 64) || STAGES < 1 || STAGES > 4) begin : g_param_err
        $error("imm_gen_pipe: XLEN must be 32/64 and STAGES 1..4");
    end

    logic [31:0]     w_imm32;
    logic            w_sext;
    logic            w_ill;
    logic [XLEN-1:0] w_imm;
    logic            w_unused;

    assign w_unused = ^in_instr[6:0];

    always_comb begin
        w_imm32 = '0;
        w_sext  = 1'b1;
        w_ill   = 1'b0;
        unique case (in_sel)
            3'b000: w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            3'b001: w_imm32 = {{20{in_instr[31]}}, in_instr[31:25],
                               in_instr[11:7]};
            3'b010: w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                               in_instr[30:25], in_instr[11:8], 1'b0};
            3'b011: w_imm32 = {in_instr[31:12], 12'b0};
            3'b100: w_imm32 = {{11{in_instr[31]}}, in_instr[31],
                               in_instr[19:12], in_instr[20],
                               in_instr[30:21], 1'b0};
            3'b101: begin
                w_imm32 = {27'b0, in_instr[19:15]};
                w_sext  = 1'b0;
            end
            3'b110: begin
                w_sext = 1'b0;
                if (XLEN == 64) w_imm32 = {26'b0, in_instr[25:20]};
                else            w_imm32 = {27'b0, in_instr[24:20]};
            end
            3'b111: w_ill = 1'b1;
        endcase
    end

    assign w_imm = w_sext ? XLEN'($signed(w_imm32)) : XLEN'(w_imm32);

    logic [STAGES-1:0] r_vld;
    logic [XLEN-1:0]   r_imm [STAGES];
    logic [STAGES-1:0] r_ill;
    logic [TAG_W-1:0]  r_tag [STAGES];

    logic [STAGES-1:0] w_free;
    logic              w_acc;
    logic [STAGES-1:0] w_src_vld;
    logic [XLEN-1:0]   w_src_imm [STAGES];
    logic [STAGES-1:0] w_src_ill;
    logic [TAG_W-1:0]  w_src_tag [STAGES];

    // A slot can take new data if it or any slot downstream has a hole,
    // or the consumer drains the tail this cycle.
    always_comb begin
        w_acc  = out_ready;
        w_free = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_acc     = w_acc || !r_vld[k];
            w_free[k] = w_acc;
        end
    end

    always_comb begin
        w_src_vld    = '0;
        w_src_ill    = '0;
        w_src_vld[0] = in_valid;
        w_src_imm[0] = w_imm;
        w_src_ill[0] = w_ill;
        w_src_tag[0] = in_tag;
        for (int k = 1; k < STAGES; k++) begin
            w_src_vld[k] = r_vld[k-1];
            w_src_imm[k] = r_imm[k-1];
            w_src_ill[k] = r_ill[k-1];
            w_src_tag[k] = r_tag[k-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld <= '0;
            r_ill <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_imm[k] <= '0;
                r_tag[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (flush)          r_vld[k] <= 1'b0;
                else if (w_free[k]) r_vld[k] <= w_src_vld[k];
                if (w_free[k] && w_src_vld[k]) begin
                    r_imm[k] <= w_src_imm[k];
                    r_ill[k] <= w_src_ill[k];
                    r_tag[k] <= w_src_tag[k];
                end
            end
        end
    end

    assign in_ready    = w_free[0];
    assign out_valid   = r_vld[STAGES-1];
    assign out_imm     = r_imm[STAGES-1];
    assign out_illegal = r_ill[STAGES-1];
    assign out_tag     = r_tag[STAGES-1];

`ifdef IMM_GEN_PIPE_STATS_EN
    logic [15:0] r_cnt;

    // Counted at accept, so entries later flushed are still included.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (in_valid && in_ready && in_sel == 3'b111
                     && r_cnt != 16'hFFFF) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign illegal_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: DUT a (XLEN=32, STAGES=3), DUT b (XLEN=64, STAGES=1).
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [63:0] imm;
        logic        ill;
        logic [4:0]  tag;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    logic        a_flush = 1'b0, a_valid = 1'b0, a_ready, a_ovalid;
    logic        a_oready = 1'b1, a_ill;
    logic [31:0] a_instr = '0, a_imm;
    logic [2:0]  a_sel = '0;
    logic [4:0]  a_tag = '0, a_otag;

    logic        b_valid = 1'b0, b_ready, b_ovalid, b_oready = 1'b1, b_ill;
    logic [31:0] b_instr = '0;
    logic [63:0] b_imm;
    logic [2:0]  b_sel = '0;
    logic [4:0]  b_tag = '0, b_otag;

`ifdef IMM_GEN_PIPE_STATS_EN
    logic [15:0] a_cnt, b_cnt;
`endif

    imm_gen_pipe #(.XLEN(32), .STAGES(3), .TAG_W(5)) u_a (
        .clk(clk), .reset(rst), .flush(a_flush),
        .in_valid(a_valid), .in_ready(a_ready), .in_instr(a_instr),
        .in_sel(a_sel), .in_tag(a_tag),
        .out_valid(a_ovalid), .out_ready(a_oready), .out_imm(a_imm),
        .out_illegal(a_ill), .out_tag(a_otag)
`ifdef IMM_GEN_PIPE_STATS_EN
        , .illegal_cnt(a_cnt)
`endif
    );

    imm_gen_pipe #(.XLEN(64), .STAGES(1), .TAG_W(5)) u_b (
        .clk(clk), .reset(rst), .flush(1'b0),
        .in_valid(b_valid), .in_ready(b_ready), .in_instr(b_instr),
        .in_sel(b_sel), .in_tag(b_tag),
        .out_valid(b_ovalid), .out_ready(b_oready), .out_imm(b_imm),
        .out_illegal(b_ill), .out_tag(b_otag)
`ifdef IMM_GEN_PIPE_STATS_EN
        , .illegal_cnt(b_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && a_ovalid && a_oready) begin
            if (qa.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_extra: got tag %h want none", a_otag);
            end else begin
                e = qa.pop_front();
                chk("a_imm", 64'(a_imm), e.imm);
                chk("a_ill", 64'(a_ill), 64'(e.ill));
                chk("a_tag", 64'(a_otag), 64'(e.tag));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && b_ovalid && b_oready) begin
            if (qb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_extra: got tag %h want none", b_otag);
            end else begin
                e = qb.pop_front();
                chk("b_imm", b_imm, e.imm);
                chk("b_ill", 64'(b_ill), 64'(e.ill));
                chk("b_tag", 64'(b_otag), 64'(e.tag));
            end
        end
    end

    task automatic push_a(input logic [31:0] ins, input logic [2:0] s,
                          input logic [4:0] t, input logic [63:0] e,
                          input logic il);
        int n = 0;
        a_valid = 1'b1; a_instr = ins; a_sel = s; a_tag = t;
        @(negedge clk);
        while (!a_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!a_ready) chk("a_accept_timeout", 64'(a_ready), 64'd1);
        else qa.push_back('{imm: e, ill: il, tag: t});
        @(posedge clk); #1;
    endtask

    task automatic push_b(input logic [31:0] ins, input logic [2:0] s,
                          input logic [4:0] t, input logic [63:0] e,
                          input logic il);
        int n = 0;
        b_valid = 1'b1; b_instr = ins; b_sel = s; b_tag = t;
        @(negedge clk);
        while (!b_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!b_ready) chk("b_accept_timeout", 64'(b_ready), 64'd1);
        else qb.push_back('{imm: e, ill: il, tag: t});
        @(posedge clk); #1;
    endtask

    task automatic drain_a();
        int n = 0;
        while (qa.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("a_drain", 64'(qa.size()), 64'd0);
        qa.delete();
    endtask

    task automatic drain_b();
        int n = 0;
        while (qb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("b_drain", 64'(qb.size()), 64'd0);
        qb.delete();
    endtask

    initial begin
        #12;
        chk("rst_a_valid", 64'(a_ovalid), 64'd0);
        chk("rst_a_imm",   64'(a_imm),    64'd0);
        chk("rst_a_ready", 64'(a_ready),  64'd1);
        chk("rst_b_valid", 64'(b_ovalid), 64'd0);
        chk("rst_b_imm",   b_imm,         64'd0);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // XLEN=64, one slot: latency 1 and 64-bit extension
        push_b(32'hFFF00093, 3'b000, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        chk("b_lat1", 64'(b_ovalid), 64'd1);
        push_b(32'h800000B7, 3'b011, 5'd2, 64'hFFFF_FFFF_8000_0000, 1'b0);
        push_b(32'h03F01013, 3'b110, 5'd3, 64'h0000_0000_0000_003F, 1'b0);
        push_b(32'h7FF00093, 3'b000, 5'd4, 64'h0000_0000_0000_07FF, 1'b0);
        push_b(32'h12345678, 3'b111, 5'd5, 64'h0, 1'b1);
        b_valid = 1'b0;
        drain_b();

        // three-slot latency
        push_a(32'hFFF00093, 3'b000, 5'd2, 64'hFFFF_FFFF, 1'b0);
        a_valid = 1'b0;
        chk("a_lat_c1", 64'(a_ovalid), 64'd0);
        @(posedge clk); #1;
        chk("a_lat_c2", 64'(a_ovalid), 64'd0);
        @(posedge clk); #1;
        chk("a_lat_c3", 64'(a_ovalid), 64'd1);
        drain_a();

        // back-to-back stream
        push_a(32'hFE000EE3, 3'b010, 5'd3, 64'hFFFF_FFFC, 1'b0);
        push_a(32'h0010006F, 3'b100, 5'd4, 64'h0000_0800, 1'b0);
        push_a(32'h123450B7, 3'b011, 5'd5, 64'h1234_5000, 1'b0);
        push_a(32'h000F8073, 3'b101, 5'd6, 64'h0000_001F, 1'b0);
        a_valid = 1'b0;
        chk("a_stream_q", 64'(qa.size()), 64'd3);
        drain_a();

        push_a(32'h03F01013, 3'b110, 5'd7, 64'h0000_001F, 1'b0);
        push_a(32'hFE112E23, 3'b001, 5'd8, 64'hFFFF_FFFC, 1'b0);
        push_a(32'hFFFFFFFF, 3'b111, 5'd9, 64'h0, 1'b1);
        a_valid = 1'b0;
        drain_a();
`ifdef IMM_GEN_PIPE_STATS_EN
        chk("a_cnt_one", 64'(a_cnt), 64'd1);
`endif

        // backpressure: fill all three slots, fourth offer must stall
        a_oready = 1'b0;
        push_a(32'h00100093, 3'b000, 5'd10, 64'h1, 1'b0);
        push_a(32'h00200093, 3'b000, 5'd11, 64'h2, 1'b0);
        push_a(32'h00300093, 3'b000, 5'd12, 64'h3, 1'b0);
        a_instr = 32'h00400093; a_tag = 5'd13;
        @(negedge clk);
        chk("a_full_ready", 64'(a_ready),  64'd0);
        chk("a_hold_vld",   64'(a_ovalid), 64'd1);
        chk("a_hold_imm",   64'(a_imm),    64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("a_hold_imm2",  64'(a_imm),    64'd1);
        chk("a_hold_tag2",  64'(a_otag),   64'd10);
        chk("a_full_ready2", 64'(a_ready), 64'd0);
        @(posedge clk); #1;
        a_oready = 1'b1;
        push_a(32'h00400093, 3'b000, 5'd13, 64'h4, 1'b0);
        a_valid = 1'b0;
        drain_a();

        // flush with two in flight and a concurrent offer
        a_oready = 1'b0;
        push_a(32'h00500093, 3'b000, 5'd14, 64'h5, 1'b0);
        push_a(32'h00600093, 3'b000, 5'd15, 64'h6, 1'b0);
        a_instr = 32'h00700093; a_tag = 5'd16; a_flush = 1'b1;
        @(negedge clk);
        chk("a_flush_ready", 64'(a_ready), 64'd1);
        @(posedge clk); #1;
        a_flush = 1'b0; a_valid = 1'b0;
        qa.delete();
        chk("a_flush_vld",    64'(a_ovalid), 64'd0);
        chk("a_flush_ready2", 64'(a_ready),  64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("a_flush_drop", 64'(a_ovalid), 64'd0);
        a_oready = 1'b1;
        push_a(32'h00800093, 3'b000, 5'd17, 64'h8, 1'b0);
        a_valid = 1'b0;
        drain_a();

        // asynchronous reset mid-stream
        a_oready = 1'b0;
        push_a(32'h00900093, 3'b000, 5'd18, 64'h9, 1'b0);
        push_a(32'h00A00093, 3'b000, 5'd19, 64'hA, 1'b0);
        a_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("a_pre_rst_vld", 64'(a_ovalid), 64'd1);
        rst = 1'b1;
        #1;
        chk("a_rst_vld",   64'(a_ovalid), 64'd0);
        chk("a_rst_imm",   64'(a_imm),    64'd0);
        chk("a_rst_tag",   64'(a_otag),   64'd0);
        chk("a_rst_ill",   64'(a_ill),    64'd0);
        chk("a_rst_ready", 64'(a_ready),  64'd1);
`ifdef IMM_GEN_PIPE_STATS_EN
        chk("a_rst_cnt",   64'(a_cnt),    64'd0);
`endif
        qa.delete();
        #2 rst = 1'b0;
        @(posedge clk); #1;
        a_oready = 1'b1;
        push_a(32'hFFFFFFFF, 3'b111, 5'd20, 64'h0, 1'b1);
        push_a(32'h00000013, 3'b111, 5'd21, 64'h0, 1'b1);
        push_a(32'h80000000, 3'b111, 5'd22, 64'h0, 1'b1);
        a_valid = 1'b0;
        drain_a();
`ifdef IMM_GEN_PIPE_STATS_EN
        chk("a_cnt_three", 64'(a_cnt), 64'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the ID/RF stage.
- Accepts a full 32-bit instruction plus a format select and a sideband tag through a valid/ready handshake.
- Decodes the immediate, extends it to XLEN, and carries it through STAGES elastic register slots to the consumer.
- Adds CSR zimm and shift-amount formats, an illegal-select flag, stall and flush.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
STAGES, 1, number of register slots; legal values 1..4.
TAG_W, 5, width of the sideband tag (rd/ROB id) carried alongside the immediate.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
flush  input  1  synchronous kill of all in-flight entries.
in_valid  input  1  upstream entry valid.
in_ready  output  1  block can accept this cycle.
in_instr  input  32  full instruction word.
in_sel  input  3  format select from the control unit.
in_tag  input  TAG_W  sideband tag, passed unmodified.
out_valid  output  1  output entry valid.
out_ready  input  1  downstream consumes this cycle.
out_imm  output  XLEN  extended immediate.
out_illegal  output  1  entry was accepted with an unsupported select.
out_tag  output  TAG_W  tag of the output entry.

Behaviour:
- Decode is combinational in front of slot 0. Slots hold only decoded results; the raw instruction is not stored.
- Format map, where i = in_instr:
  - 000 I: i[31:20], sign-extended.
  - 001 S: {i[31:25], i[11:7]}, sign-extended.
  - 010 B: {i[31], i[7], i[30:25], i[11:8], 0}, sign-extended.
  - 011 U: {i[31:12], 12'b0}, sign-extended to XLEN.
  - 100 J: {i[31], i[19:12], i[20], i[30:21], 0}, sign-extended.
  - 101 Z: i[19:15], zero-extended (CSR immediate forms).
  - 110 SH: i[25:20] when XLEN=64, i[24:20] when XLEN=32; zero-extended.
  - 111: immediate 0 and illegal=1.
- Every select other than 111 gives illegal=0.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Slot k advances into slot k+1 when slot k+1 is empty or slot k+1 itself advances. The last slot drains on output transfer.
  - in_ready = !slot0_valid || slot0_advances. It is combinational from out_ready, with no registered skid.
- Latency and capacity:
  - Latency is exactly STAGES cycles from accept to out_valid when there is no backpressure.
  - Throughput is 1 entry per cycle.
  - Capacity is STAGES entries.
- out_imm, out_illegal and out_tag are driven from the last slot. They hold stable while out_valid && !out_ready.
- flush:
  - On the next edge, all slot valids clear to 0.
  - Any accept in that same cycle is discarded; flush has priority.
  - in_ready is still computed normally during the flush cycle.
  - Slot data is not cleared.
- Reset (asynchronous, any cycle, including mid-stream):
  - All slot valids, data and tags go to 0.
  - out_valid=0, out_imm=0, out_illegal=0, out_tag=0.
  - in_ready=1 after reset.
- Parameter checks: XLEN outside {32,64} or STAGES outside 1..4 raises an elaboration-time error.

Optional Feature:
- Macro: IMM_GEN_PIPE_STATS_EN.
- When defined:
  - Adds output port illegal_cnt (16 bits).
  - illegal_cnt increments on each accepted entry with in_sel=111 and saturates at 0xFFFF.
  - Reset clears it; flush does not.
  - The count is taken at accept, so it counts entries later flushed.
- When undefined: no port, no counter logic, and behaviour is otherwise identical.

Test Plan:
1. XLEN=32, STAGES=1, out_ready=1; accept 0xFFF00093 sel=000 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_illegal=0.
2. Back-to-back stream, STAGES=3: sel=010 0xFE000EE3, then sel=100 0x0010006F, then sel=011 0x123450B7, then sel=101 0x000F8073 -> outputs in order 0xFFFFFFFC, 0x00000800, 0x12345000, 0x0000001F. First output appears 3 cycles after the first accept, then one per cycle.
3. XLEN=64, sel=110, instr 0x03F01013 (slli x0,x0,63) -> out_imm=0x000000000000003F. Same instr with XLEN=32 -> 0x0000001F.
4. Backpressure, STAGES=2, out_ready=0; offer 3 entries -> in_ready drops after 2 accepts and the output holds entry 1 stable. Raise out_ready -> entries 1, 2, 3 delivered in order with no loss or duplication.
5. Flush with 2 entries in flight and in_valid=1 -> next cycle out_valid=0, the offered entry is not accepted, in_ready=1. A later accept completes normally.
6. Assert reset mid-stream between clock edges -> out_valid, out_imm, out_tag (and illegal_cnt when the macro is defined) go to 0 immediately. With the macro, 3 sel=111 accepts after reset -> illegal_cnt=3 and out_illegal=1 on each.
